// File: rtl/tft_pkg.sv
// Shared TFT definitions: byte width, D/C select values and the bus arbiter state encoding.
// Used by the arbiter, tft_init and scene_exhibitor.
package tft_pkg;

   localparam int unsigned TFT_DATA_W = 8;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_DRAIN
   } arb_state_e;

   // Index width that stays legal for a single requester.
   function automatic int unsigned id_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tft_bus_arbiter_if.sv
// Requester-side and SPI-side signals of the TFT bus arbiter.
// The arbiter takes the slave view; the requesters/tft_spi side takes the master view.
interface tft_bus_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = tft_pkg::TFT_DATA_W
) ();
   import tft_pkg::*;

   localparam int unsigned ID_W = id_width(N_REQ);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_dc;
   logic [N_REQ-1:0]        req_transmit;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        req_tft_busy;
   logic [DATA_W-1:0]       spi_data;
   logic                    spi_dc;
   logic                    spi_transmit;
   logic                    spi_busy;
   logic [ID_W-1:0]         owner_id;
   logic                    timeout;

   modport slave (
      input  req, req_data, req_dc, req_transmit, spi_busy,
      output gnt, req_tft_busy, spi_data, spi_dc, spi_transmit, owner_id, timeout
   );

   modport master (
      output req, req_data, req_dc, req_transmit, spi_busy,
      input  gnt, req_tft_busy, spi_data, spi_dc, spi_transmit, owner_id, timeout
   );

endinterface

// File: rtl/tft_rr_picker.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin starting
// after the last winner. Produces a one-hot winner, its index and a valid flag.
module tft_rr_picker import tft_pkg::*; #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last,
   input  logic             rr_mode,
   output logic [N_REQ-1:0] winner,
   output logic [ID_W-1:0]  winner_id,
   output logic             valid
);

   always_comb begin
      int unsigned j;
      j         = 0;
      winner    = '0;
      winner_id = '0;
      valid     = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = rr_mode ? (32'(last) + 32'd1 + k) % N_REQ : k;
         if (!valid && req[ID_W'(j)]) begin
            valid     = 1'b1;
            winner_id = ID_W'(j);
         end
      end
      if (valid) winner[winner_id] = 1'b1;
   end

endmodule

// File: rtl/tft_bus_arbiter.sv
// Shares one tft_spi transmitter among N_REQ sources: locks the bus for a whole burst,
// forwards the owner's strobes, and revokes stalled grants with a watchdog.
module tft_bus_arbiter import tft_pkg::*; #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_W     = TFT_DATA_W,
   parameter int unsigned RR_MODE    = 0,
   parameter int unsigned IDLE_LIMIT = 4096
) (
   input logic              clk,
   input logic              rst,
   tft_bus_arbiter_if.slave bus
);

   localparam int unsigned ID_W  = id_width(N_REQ);
   localparam int unsigned CNT_W = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(IDLE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(IDLE_LIMIT - 1);

   arb_state_e        state;
   logic [N_REQ-1:0]  gnt_q;
   logic [ID_W-1:0]   owner_q;
   logic [ID_W-1:0]   last_q;
   logic [CNT_W-1:0]  idle_cnt;
   logic [DATA_W-1:0] data_q;
   logic              dc_q;
   logic              tx_q;
   logic              timeout_q;

   logic [N_REQ-1:0]  pick;
   logic [ID_W-1:0]   pick_id;
   logic              pick_valid;
   logic [N_REQ-1:0]  busy_vec;
   logic              own_req;
   logic              accept;

   tft_rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req       (bus.req),
      .last      (last_q),
      .rr_mode   (RR_MODE != 0),
      .winner    (pick),
      .winner_id (pick_id),
      .valid     (pick_valid)
   );

   // tx_q term covers the cycle before tft_spi raises busy, so the owner cannot double-strobe.
   assign busy_vec = ~gnt_q | {N_REQ{bus.spi_busy | tx_q}};
   assign own_req  = bus.req[owner_q];
   assign accept   = bus.req_transmit[owner_q] & ~busy_vec[owner_q];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ARB_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         last_q    <= ID_W'(N_REQ - 1);
         idle_cnt  <= '0;
         data_q    <= '0;
         dc_q      <= 1'b0;
         tx_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         tx_q      <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (!bus.spi_busy && pick_valid) begin
                  gnt_q    <= pick;
                  owner_q  <= pick_id;
                  last_q   <= pick_id;
                  idle_cnt <= '0;
                  state    <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (!own_req) begin
                  gnt_q <= '0;
                  state <= ARB_DRAIN;
               end else if (accept) begin
                  tx_q     <= 1'b1;
                  data_q   <= bus.req_data[owner_q*DATA_W +: DATA_W];
                  dc_q     <= bus.req_dc[owner_q];
                  idle_cnt <= '0;
               end else if (IDLE_LIMIT != 0) begin
                  if (idle_cnt == LIMIT_M1) begin
                     idle_cnt  <= LIMIT;
                     timeout_q <= 1'b1;
                     gnt_q     <= '0;
                     state     <= ARB_DRAIN;
                  end else if (idle_cnt != LIMIT) begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            ARB_DRAIN: begin
               if (!bus.spi_busy && !tx_q) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.req_tft_busy = busy_vec;
   assign bus.spi_data     = data_q;
   assign bus.spi_dc       = dc_q;
   assign bus.spi_transmit = tx_q;
   assign bus.owner_id     = owner_q;
   assign bus.timeout      = timeout_q;

endmodule
